// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round sequencer: IDLE -> COLLECT -> JUDGE -> SHOW, with saturating scores.
// Optional COLLECT timeout with forfeit is built only when ROUND_TIMEOUT_EN is defined.

module rps_choice_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] pulse_i,
  output logic [2:0] choice_o
);
  logic [2:0] choice_q, choice_d;

  // First nonzero vector wins, rock > paper > scissors; a latched choice is frozen.
  always_comb begin
    choice_d = choice_q;
    if (clr_i) begin
      choice_d = 3'b000;
    end else if (en_i && choice_q == 3'b000) begin
      if (pulse_i[0])      choice_d = 3'b001;
      else if (pulse_i[1]) choice_d = 3'b010;
      else if (pulse_i[2]) choice_d = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) choice_q <= 3'b000;
    else      choice_q <= choice_d;
  end

  assign choice_o = choice_q;
endmodule

module rps_round_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic [2:0] a_pulse,
  input  logic [2:0] b_pulse,
  output logic [1:0] state,
  output logic [2:0] a_choice,
  output logic [2:0] b_choice,
  output logic [1:0] winner,
  output logic       result_valid,
  output logic       timed_out,
  output logic [3:0] score_a,
  output logic [3:0] score_b
);
  localparam int NUM_PLAYERS = 2;
`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int unsigned CNT_MAX = SHOW_CYCLES;
`endif
  localparam int TW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  if (SHOW_CYCLES < 1) begin : g_bad_show
    $error("SHOW_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    JUDGE   = 2'd2,
    SHOW    = 2'd3
  } state_e;

  state_e  state_q;
  logic [TW-1:0] timer_q;
  logic [1:0] winner_q;
  logic       rv_q;
  logic [3:0] score_a_q, score_b_q;

  logic [NUM_PLAYERS-1:0][2:0] pulse_vec;
  logic [NUM_PLAYERS-1:0][2:0] choice_vec;
  logic       clr_choice, en_choice, both_latched;
  logic [1:0] judge_d;
  logic [2:0] a_ch, b_ch;

  assign pulse_vec  = {b_pulse, a_pulse};
  // Clearing happens on the restart edge itself, so a pulse in that cycle is dropped.
  assign clr_choice = start_pulse && (state_q == IDLE || state_q == SHOW);
  assign en_choice  = (state_q == COLLECT);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    rps_choice_latch u_latch (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr_choice),
      .en_i     (en_choice),
      .pulse_i  (pulse_vec[p]),
      .choice_o (choice_vec[p])
    );
  end

  assign a_ch         = choice_vec[0];
  assign b_ch         = choice_vec[1];
  assign both_latched = (a_ch != 3'b000) && (b_ch != 3'b000);

  // One-hot rotate: A beats B exactly when B is A rotated right by one.
  always_comb begin
    judge_d = 2'b00;
    if (a_ch == 3'b000 && b_ch == 3'b000) judge_d = 2'b00;
    else if (a_ch == 3'b000)              judge_d = 2'b10;
    else if (b_ch == 3'b000)              judge_d = 2'b01;
    else if (a_ch == b_ch)                judge_d = 2'b00;
    else if (b_ch == {a_ch[0], a_ch[2:1]}) judge_d = 2'b01;
    else                                  judge_d = 2'b10;
  end

`ifdef ROUND_TIMEOUT_EN
  logic to_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      winner_q  <= 2'b00;
      rv_q      <= 1'b0;
      score_a_q <= 4'd0;
      score_b_q <= 4'd0;
`ifdef ROUND_TIMEOUT_EN
      to_q      <= 1'b0;
`endif
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            state_q  <= COLLECT;
            winner_q <= 2'b00;
            timer_q  <= '0;
`ifdef ROUND_TIMEOUT_EN
            to_q     <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (both_latched) begin
            state_q <= JUDGE;
          end
`ifdef ROUND_TIMEOUT_EN
          else begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state_q <= JUDGE;
              to_q    <= 1'b1;
            end
          end
`endif
        end
        JUDGE: begin
          winner_q <= judge_d;
          if (judge_d == 2'b01 && score_a_q != 4'hF) score_a_q <= score_a_q + 4'd1;
          if (judge_d == 2'b10 && score_b_q != 4'hF) score_b_q <= score_b_q + 4'd1;
          rv_q    <= 1'b1;
          timer_q <= '0;
          state_q <= SHOW;
        end
        SHOW: begin
          if (start_pulse) begin
            state_q  <= COLLECT;
            winner_q <= 2'b00;
            timer_q  <= '0;
`ifdef ROUND_TIMEOUT_EN
            to_q     <= 1'b0;
`endif
          end else if (timer_q == TW'(SHOW_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign a_choice     = a_ch;
  assign b_choice     = b_ch;
  assign winner       = winner_q;
  assign result_valid = rv_q;
  assign score_a      = score_a_q;
  assign score_b      = score_b_q;
`ifdef ROUND_TIMEOUT_EN
  assign timed_out    = to_q;
`else
  assign timed_out    = 1'b0;
`endif
endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: directed rounds with literal expectations plus a randomized
// run compared every cycle against a behavioural round model.
`timescale 1ns/1ps
module tb_rps_round_ctrl;
  localparam int SHOW = 4;
  localparam int TMO  = 16;
`ifdef ROUND_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_pulse = 1'b0;
  logic [2:0] a_pulse = 3'b000;
  logic [2:0] b_pulse = 3'b000;
  logic [1:0] state, winner;
  logic [2:0] a_choice, b_choice;
  logic       result_valid, timed_out;
  logic [3:0] score_a, score_b;

  int checks = 0;
  int errors = 0;

  rps_round_ctrl #(.SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .a_pulse(a_pulse), .b_pulse(b_pulse),
    .state(state), .a_choice(a_choice), .b_choice(b_choice), .winner(winner),
    .result_valid(result_valid), .timed_out(timed_out), .score_a(score_a), .score_b(score_b)
  );

  always #5 clk = ~clk;

  // ---- behavioural model: choices as indices 0 rock, 1 paper, 2 scissors, -1 none ----
  int m_state = 0, m_a = -1, m_b = -1, m_win = 0, m_rv = 0, m_to = 0;
  int m_sa = 0, m_sb = 0, m_elapsed = 0, m_shown = 0;

  function automatic int first_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int onehot(input int idx);
    return (idx < 0) ? 0 : (1 << idx);
  endfunction

  function automatic int judge(input int a, input int b);
    if (a < 0 && b < 0) return 0;
    if (a < 0) return 2;
    if (b < 0) return 1;
    if (a == b) return 0;
    return (((a - b + 3) % 3) == 1) ? 1 : 2;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0; m_a <= -1; m_b <= -1; m_win <= 0; m_rv <= 0; m_to <= 0;
      m_sa <= 0; m_sb <= 0; m_elapsed <= 0; m_shown <= 0;
    end else begin
      m_rv <= 0;
      if ((m_state == 0 || m_state == 3) && start_pulse) begin
        m_state <= 1; m_a <= -1; m_b <= -1; m_win <= 0; m_to <= 0; m_elapsed <= 0;
      end else if (m_state == 1) begin
        if (m_a >= 0 && m_b >= 0) m_state <= 2;
        else begin
          if (m_a < 0 && a_pulse != 0) m_a <= first_idx(a_pulse);
          if (m_b < 0 && b_pulse != 0) m_b <= first_idx(b_pulse);
          if (TO_EN && m_elapsed + 1 == TMO) begin m_state <= 2; m_to <= 1; end
          m_elapsed <= m_elapsed + 1;
        end
      end else if (m_state == 2) begin
        m_win <= judge(m_a, m_b);
        if (judge(m_a, m_b) == 1) m_sa <= (m_sa < 15) ? m_sa + 1 : 15;
        if (judge(m_a, m_b) == 2) m_sb <= (m_sb < 15) ? m_sb + 1 : 15;
        m_state <= 3; m_rv <= 1; m_shown <= 0;
      end else if (m_state == 3) begin
        if (m_shown + 1 == SHOW) m_state <= 0;
        else m_shown <= m_shown + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m.state", state, m_state);
    chk("m.a_choice", a_choice, onehot(m_a));
    chk("m.b_choice", b_choice, onehot(m_b));
    chk("m.winner", winner, m_win);
    chk("m.result_valid", result_valid, m_rv);
    chk("m.timed_out", timed_out, m_to);
    chk("m.score_a", score_a, m_sa);
    chk("m.score_b", score_b, m_sb);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic s, input logic [2:0] a, input logic [2:0] b);
    start_pulse = s; a_pulse = a; b_pulse = b;
    tick();
    start_pulse = 1'b0; a_pulse = 3'b000; b_pulse = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(2); rst = 1'b1; tick();
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst.state", state, 0);
    chk("rst.choices", {a_choice, b_choice}, 0);
    chk("rst.scores", {score_a, score_b}, 0);
    chk("rst.flags", {winner, result_valid, timed_out}, 0);
    rst = 1'b1; tick();

    // Basic round: A rock, later B scissors
    drive(1'b1, 3'b000, 3'b000);
    chk("basic.collect", state, 1);
    tick(3);
    drive(1'b0, 3'b001, 3'b000);
    chk("basic.a_rock", a_choice, 3'b001);
    tick(3);
    drive(1'b0, 3'b000, 3'b100);
    chk("basic.b_scis", b_choice, 3'b100);
    chk("basic.still_collect", state, 1);
    tick(); chk("basic.judge", state, 2);
    chk("basic.rv_not_yet", result_valid, 0);
    tick();
    chk("basic.show", state, 3);
    chk("basic.winner", winner, 2'b01);
    chk("basic.score_a", score_a, 1);
    chk("basic.rv", result_valid, 1);
    tick(); chk("basic.rv_pulse", result_valid, 0);
    tick(SHOW); chk("basic.idle", state, 0);
    chk("basic.hold_winner", winner, 2'b01);

    // Pulses while idle are ignored
    drive(1'b0, 3'b010, 3'b010);
    chk("idle.ignore", {a_choice, b_choice}, {3'b001, 3'b100});

    // Simultaneous multi-bit vectors; later A pulse cannot change the latch
    drive(1'b1, 3'b111, 3'b110);
    chk("multi.entry_ignored", {a_choice, b_choice}, 0);
    drive(1'b0, 3'b111, 3'b110);
    chk("multi.a", a_choice, 3'b001);
    chk("multi.b", b_choice, 3'b010);
    drive(1'b0, 3'b100, 3'b000);
    chk("multi.a_frozen", a_choice, 3'b001);
    chk("multi.judge", state, 2);
    tick();
    chk("multi.winner", winner, 2'b10);
    chk("multi.score_b", score_b, 1);

    // Saturation: 16 A wins after reset
    do_reset();
    for (int r = 0; r < 16; r++) begin
      drive(1'b1, 3'b000, 3'b000);
      drive(1'b0, 3'b010, 3'b001);
      tick(2 + SHOW);
    end
    chk("sat.score_a", score_a, 15);
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b100, 3'b010);
    tick(2);
    chk("sat.still15", score_a, 15);
    chk("sat.show", state, 3);
    drive(1'b1, 3'b000, 3'b000);
    chk("restart.collect", state, 1);
    chk("restart.cleared", {a_choice, b_choice, winner}, 0);
    chk("restart.rv", result_valid, 0);

`ifdef ROUND_TIMEOUT_EN
    // Timeout forfeit: only B presses paper
    do_reset();
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b000, 3'b010);
    tick(TMO - 2);
    chk("tmo.last_collect", state, 1);
    tick();
    chk("tmo.judge", state, 2);
    chk("tmo.flag", timed_out, 1);
    tick();
    chk("tmo.winner", winner, 2'b10);
    chk("tmo.score_b", score_b, 1);
    drive(1'b1, 3'b000, 3'b000);
    chk("tmo.flag_clr", timed_out, 0);
    tick(TMO);
    chk("tmo2.judge", state, 2);
    tick();
    chk("tmo2.draw", winner, 2'b00);
    chk("tmo2.flag", timed_out, 1);
`else
    // Without the timeout COLLECT waits indefinitely
    drive(1'b0, 3'b001, 3'b000);
    tick(3 * TMO);
    chk("wait.collect", state, 1);
    chk("wait.no_flag", timed_out, 0);
`endif

    // Reset asserted in JUDGE
    do_reset();
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b001, 3'b100);
    tick();
    chk("rmid.judge", state, 2);
    rst = 1'b0; #1;
    chk("rmid.state", state, 0);
    chk("rmid.outs", {a_choice, b_choice, winner, result_valid, timed_out, score_a, score_b}, 0);
    tick(); rst = 1'b1; tick(SHOW + 3);
    chk("rmid.no_score", {score_a, score_b}, 0);

    // Randomized run, model compared every cycle
    for (int c = 0; c < 4000; c++) begin
      start_pulse = ($urandom_range(0, 15) == 0);
      a_pulse = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      b_pulse = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      else rst = 1'b1;
      tick();
    end
    rst = 1'b1; start_pulse = 1'b0; a_pulse = 3'b000; b_pulse = 3'b000;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rps_round_ctrl.md
# rps_round_ctrl

Round sequencer for the rock-paper-scissors game. It consumes the single-cycle `key_pulse` outputs of the per-key `debounce` instances, six player keys plus one start key. For each player it latches the first valid choice, judges the round, holds the result for display, and keeps saturating win counters. It sits between the debounce layer and the display/LED drivers.

## Interface
- `SHOW_CYCLES`, default 100_000_000: cycles the result is held in SHOW (2 s at 50 MHz); must be ≥1.
- `TIMEOUT_CYCLES`, default 250_000_000: maximum cycles spent in COLLECT (5 s at 50 MHz); must be ≥2; used only with `ROUND_TIMEOUT_EN`.
- `clk`, input, 1: system clock, 50 MHz.
- `rst`, input, 1: asynchronous, active-low reset.
- `start_pulse`, input, 1: debounced start key, one-cycle pulse.
- `a_pulse`, input, 3: player A debounced keys; bit0 rock, bit1 paper, bit2 scissors.
- `b_pulse`, input, 3: player B debounced keys, same bit mapping as `a_pulse`.
- `state`, output, 2: current state; IDLE=0, COLLECT=1, JUDGE=2, SHOW=3.
- `a_choice`, output, 3: player A latched choice, one-hot; 000 means none.
- `b_choice`, output, 3: player B latched choice, one-hot; 000 means none.
- `winner`, output, 2: 00 draw, 01 A, 10 B; 11 is never driven.
- `result_valid`, output, 1: one-cycle pulse on entry to SHOW.
- `timed_out`, output, 1: the last round ended by timeout.
- `score_a`, output, 4: player A wins, saturating at 15.
- `score_b`, output, 4: player B wins, saturating at 15.

## Operation
- **Reset (async, `rst`=0):**
  - `state`=IDLE.
  - All choices, `winner`, `result_valid`, `timed_out`, scores and timers = 0.
  - A reset mid-round discards the round and never increments a score.
- **IDLE:**
  - Choices, `winner` and `timed_out` hold the previous round's values.
  - On `start_pulse`: go to COLLECT; clear both choices, `winner`, `timed_out` and the timer.
  - Player pulses are ignored.
- **COLLECT:**
  - While a player's choice is 000, any nonzero pulse vector latches a one-hot choice.
  - Priority within one vector is rock > paper > scissors; e.g. 3'b110 latches paper.
  - Once a choice is latched, further pulses from that player are ignored; a choice cannot change.
  - Both players may latch in the same cycle.
  - When both choices are nonzero (checked on the registered values), go to JUDGE.
  - `start_pulse` is ignored.
- **JUDGE (exactly one cycle):**
  - Winner rules: rock beats scissors, scissors beats paper, paper beats rock, equal choices draw.
  - Forfeit: only one player latched means that player wins; neither latched means draw.
  - Register `winner`, increment the winner's score (saturate at 15), go to SHOW.
- **SHOW:**
  - `result_valid`=1 in the first SHOW cycle only.
  - Hold for `SHOW_CYCLES` cycles, then go to IDLE.
  - `start_pulse` in any SHOW cycle goes directly to COLLECT and clears as in IDLE.
- **Score counters:** cleared only by reset.

## Timing
- A pulse in cycle n makes the choice visible in cycle n+1.
- If the second choice latches in cycle n:
  - `state`=JUDGE at n+1.
  - `state`=SHOW at n+2, with `winner`, updated score and `result_valid` valid at n+2.
- `start_pulse` in cycle n gives `state`=COLLECT at n+1.
- A pulse coincident with a state change into COLLECT is ignored; pulses count only while `state` is already COLLECT.
- SHOW lasts exactly `SHOW_CYCLES` cycles, absent start.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `ROUND_TIMEOUT_EN`.
- **Defined:**
  - A timer counts cycles in COLLECT, starting at 0 on the COLLECT entry cycle.
  - If both choices are not yet latched in the COLLECT cycle where timer = `TIMEOUT_CYCLES`-1, go to JUDGE and set `timed_out`=1.
  - Forfeit rules apply.
  - A choice latching in that same final cycle is accepted, and the normal rules decide if both are then latched; `timed_out` is still 1.
- **Undefined:**
  - No timer logic.
  - `timed_out` is tied to 0.
  - COLLECT waits indefinitely.

## Test plan
- **Basic round:** reset, `start_pulse`, A rock at cycle 5, B scissors at cycle 9 → `winner`=01, `score_a`=1, `result_valid` one cycle, 2 cycles after B latches.
- **Simultaneous multi-bit:** both players latch the same cycle, with `a_pulse`=3'b111 and `b_pulse`=3'b110 → `a_choice`=001, `b_choice`=010, `winner`=10; later A pulses do not change `a_choice`.
- **Timeout forfeit:** with `ROUND_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16 and only B pressing paper → JUDGE after 16 COLLECT cycles, `timed_out`=1, `winner`=10; with no presses at all → `winner`=00.
- **Saturation and restart:** 16 A wins (`SHOW_CYCLES`=4) → `score_a` stays 15; `start_pulse` during SHOW → COLLECT next cycle with choices 000.
- **Reset mid-round:** assert `rst`=0 in JUDGE → all outputs 0 immediately; no score change after release.
